// File: rtl/sweep_acq_pkg.sv
// Shared types and constants for the sweep acquisition engine.
// The optional per-point timeout is enabled with the SWEEP_TIMEOUT_EN macro.
package sweep_acq_pkg;

  localparam int DEF_DAC_W      = 10;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FIFO_DEPTH = 128;
  localparam int DEF_TIMEOUT_W  = 24;

  localparam int FIFO_AW = $clog2(DEF_FIFO_DEPTH);

  // Tag bits placed above the DAC code in every per-point header word.
  localparam logic [DEF_DATA_W-DEF_DAC_W-1:0] HEADER_PREFIX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_SC,
    S_WAIT_CFG,
    S_ACQ,
    S_HEADER,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/sweep_acq_fifo.sv
// Per-point synchronous buffer: registered read data, full/empty flags and a
// synchronous flush that empties it in one cycle.
module sweep_acq_fifo
  import sweep_acq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int AW     = FIFO_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              do_wr;
  logic              do_rd;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_wr = wr_en_i && !full_o && !flush_i;
  assign do_rd = rd_en_i && !empty_o && !flush_i;

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sweep_acq_engine.sv
// Threshold DAC sweep: per point reload slow control, acquire, buffer, then
// emit a tagged header plus the buffered words. Timeout via SWEEP_TIMEOUT_EN.
module sweep_acq_engine
  import sweep_acq_pkg::*;
#(
  parameter int DAC_W      = DEF_DAC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_W  = DEF_TIMEOUT_W
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 SweepStart,
  input  logic                 SweepAbort,
  input  logic [DAC_W-1:0]     StartDAC,
  input  logic [DAC_W-1:0]     EndDAC,
  input  logic [DAC_W-1:0]     DACStep,
  input  logic [CNT_W-1:0]     MaxPackageNumber,
  input  logic [TIMEOUT_W-1:0] TimeoutCycles,
  input  logic [DATA_W-1:0]    ParallelData,
  input  logic                 ParallelData_en,
  output logic [DAC_W-1:0]     OutDAC,
  output logic                 LoadSCParameter,
  input  logic                 MicrorocConfigDone,
  output logic                 SingleACQStart,
  output logic [DATA_W-1:0]    SweepACQData,
  output logic                 SweepACQData_en,
  output logic                 ACQDone,
  output logic                 Busy,
  output logic                 Overflow,
  output logic                 TimeoutFlag
);

  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-DAC_W-1:0] HDR_ONES = {(DATA_W-DAC_W){HEADER_PREFIX[0]}};
  localparam logic [DAC_W-1:0] STEP_ONE = {{(DAC_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              start_s1_q, start_s2_q;
  logic [DAC_W-1:0]  out_dac_q, out_dac_d;
  logic [DAC_W-1:0]  end_q, end_d;
  logic [DAC_W-1:0]  step_q, step_d;
  logic              down_q, down_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hdr_q, hdr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              ovf_q, ovf_d;

  logic              start_edge;
  logic              start_accept;
  logic              abort_now;
  logic              max_hit;
  logic              tmo_hit;
  logic [DAC_W:0]    nxt_up;
  logic [DAC_W:0]    nxt_dn;

  logic              fifo_wr, fifo_rd, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign start_edge   = start_s1_q && !start_s2_q;
  assign start_accept = (state_q == S_IDLE) && start_edge;
  assign abort_now    = SweepAbort && (state_q != S_IDLE);
  assign max_hit      = ParallelData_en && ((cnt_q + 1'b1) == MaxPackageNumber);

  // One extra bit exposes overflow past 2^DAC_W and borrow below zero.
  assign nxt_up = {1'b0, out_dac_q} + {1'b0, step_q};
  assign nxt_dn = {1'b0, out_dac_q} - {1'b0, step_q};

`ifdef SWEEP_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 tmo_flag_q;

  assign tmo_hit = (TimeoutCycles != '0) && (tmo_cnt_q == TimeoutCycles - 1'b1);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == S_ACQ) ? tmo_cnt_q + 1'b1 : '0;
      if (start_accept) begin
        tmo_flag_q <= 1'b0;
      end else if ((state_q == S_ACQ) && tmo_hit && !max_hit && !abort_now) begin
        tmo_flag_q <= 1'b1;
      end
    end
  end

  assign TimeoutFlag = tmo_flag_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign tmo_hit        = 1'b0;
  assign TimeoutFlag    = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    out_dac_d  = out_dac_q;
    end_d      = end_q;
    step_d     = step_q;
    down_d     = down_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    hdr_d      = 1'b0;
    rd_pend_d  = 1'b0;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          out_dac_d  = StartDAC;
          end_d      = EndDAC;
          step_d     = (DACStep == '0) ? STEP_ONE : DACStep;
          down_d     = (EndDAC < StartDAC);
          ovf_d      = 1'b0;
          fifo_flush = 1'b1;
          state_d    = S_LOAD_SC;
        end
      end
      S_LOAD_SC: state_d = S_WAIT_CFG;
      S_WAIT_CFG: begin
        cnt_d = '0;
        if (MicrorocConfigDone) begin
          state_d = (MaxPackageNumber == '0) ? S_HEADER : S_ACQ;
        end
      end
      S_ACQ: begin
        if (ParallelData_en) begin
          cnt_d = cnt_q + 1'b1;
          if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            fifo_wr = 1'b1;
          end
        end
        if (max_hit || tmo_hit) begin
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        hdr_d   = 1'b1;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          rd_pend_d = 1'b1;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!down_q) begin
          if (nxt_up[DAC_W] || (nxt_up[DAC_W-1:0] > end_q)) begin
            state_d = S_DONE;
          end else begin
            out_dac_d = nxt_up[DAC_W-1:0];
            state_d   = S_LOAD_SC;
          end
        end else begin
          if (nxt_dn[DAC_W] || (nxt_dn[DAC_W-1:0] < end_q)) begin
            state_d = S_DONE;
          end else begin
            out_dac_d = nxt_dn[DAC_W-1:0];
            state_d   = S_LOAD_SC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition and cancels anything still in flight.
    if (abort_now) begin
      state_d    = S_IDLE;
      fifo_flush = 1'b1;
      fifo_wr    = 1'b0;
      fifo_rd    = 1'b0;
      hdr_d      = 1'b0;
      rd_pend_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      out_dac_q  <= '0;
      end_q      <= '0;
      step_q     <= '0;
      down_q     <= 1'b0;
      cnt_q      <= '0;
      hdr_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_s1_q <= SweepStart;
      start_s2_q <= start_s1_q;
      out_dac_q  <= out_dac_d;
      end_q      <= end_d;
      step_q     <= step_d;
      down_q     <= down_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      rd_pend_q  <= rd_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  sweep_acq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .AW     (FIFO_ADDR_W)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (reset_n),
    .flush_i   (fifo_flush),
    .wr_en_i   (fifo_wr),
    .wr_data_i (ParallelData),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Header and FIFO read data are never valid in the same cycle.
  always_comb begin
    SweepACQData = '0;
    if (hdr_q) begin
      SweepACQData = {HDR_ONES, out_dac_q};
    end else if (rd_pend_q) begin
      SweepACQData = fifo_rdata;
    end
  end

  assign SweepACQData_en = hdr_q || rd_pend_q;
  assign OutDAC          = out_dac_q;
  assign LoadSCParameter = (state_q == S_LOAD_SC);
  assign SingleACQStart  = (state_q == S_ACQ);
  assign ACQDone         = (state_q == S_DONE);
  assign Busy            = (state_q != S_IDLE);
  assign Overflow        = ovf_q;

endmodule

// File: tb/tb_sweep_acq_engine.sv
// Self-checking bench for sweep_acq_engine: randomized acquisition data and
// sweep parameters checked against a point-list / word-stream reference model.
module tb_sweep_acq_engine;

  localparam int DAC_W      = 10;
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 128;
  localparam int TIMEOUT_W  = 24;
  localparam int HDR_BASE   = ((1 << DATA_W) - 1) - ((1 << DAC_W) - 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 SweepStart, SweepAbort;
  logic [DAC_W-1:0]     StartDAC, EndDAC, DACStep;
  logic [CNT_W-1:0]     MaxPackageNumber;
  logic [TIMEOUT_W-1:0] TimeoutCycles;
  logic [DATA_W-1:0]    ParallelData;
  logic                 ParallelData_en;
  logic [DAC_W-1:0]     OutDAC;
  logic                 LoadSCParameter;
  logic                 MicrorocConfigDone;
  logic                 SingleACQStart;
  logic [DATA_W-1:0]    SweepACQData;
  logic                 SweepACQData_en;
  logic                 ACQDone, Busy, Overflow, TimeoutFlag;

  always #5 clk = ~clk;

  sweep_acq_engine dut (
    .Clk                (clk),
    .reset_n            (rst_n),
    .SweepStart         (SweepStart),
    .SweepAbort         (SweepAbort),
    .StartDAC           (StartDAC),
    .EndDAC             (EndDAC),
    .DACStep            (DACStep),
    .MaxPackageNumber   (MaxPackageNumber),
    .TimeoutCycles      (TimeoutCycles),
    .ParallelData       (ParallelData),
    .ParallelData_en    (ParallelData_en),
    .OutDAC             (OutDAC),
    .LoadSCParameter    (LoadSCParameter),
    .MicrorocConfigDone (MicrorocConfigDone),
    .SingleACQStart     (SingleACQStart),
    .SweepACQData       (SweepACQData),
    .SweepACQData_en    (SweepACQData_en),
    .ACQDone            (ACQDone),
    .Busy               (Busy),
    .Overflow           (Overflow),
    .TimeoutFlag        (TimeoutFlag)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [DATA_W-1:0] act_q[$];
  logic [DATA_W-1:0] sent_q[$];
  int                stored_cnt[$];
  int                dac_seen[$];
  int                done_cnt, acq_cyc, extra_acq, sent_pt, words_pp, cfg_delay;
  bit                acq_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor.
  initial forever begin
    @(negedge clk);
    if (SweepACQData_en) act_q.push_back(SweepACQData);
    if (LoadSCParameter) dac_seen.push_back(int'(OutDAC));
    if (ACQDone) done_cnt++;
    if (SingleACQStart) acq_cyc++;
  end

  // Acquisition source: random data with random gaps while SingleACQStart is high.
  initial begin
    ParallelData_en = 1'b0;
    ParallelData    = '0;
    acq_prev        = 1'b0;
    forever begin
      @(negedge clk);
      ParallelData_en = 1'b0;
      if (SingleACQStart) begin
        if (!acq_prev) begin
          stored_cnt.push_back(0);
          sent_pt = 0;
        end
        if (sent_pt < words_pp) begin
          if ($urandom_range(0, 3) != 0) begin
            ParallelData    = DATA_W'($urandom);
            ParallelData_en = 1'b1;
            if (sent_pt < FIFO_DEPTH) begin
              sent_q.push_back(ParallelData);
              stored_cnt[stored_cnt.size()-1]++;
            end
            sent_pt++;
          end
        end else begin
          extra_acq++;
        end
      end
      acq_prev = SingleACQStart;
    end
  end

  // Slow-control responder: config-done rises cfg_delay cycles after each load.
  initial begin
    MicrorocConfigDone = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_delay == 0) begin
        MicrorocConfigDone = 1'b1;
      end else if (LoadSCParameter) begin
        MicrorocConfigDone = 1'b0;
        repeat (cfg_delay) @(negedge clk);
        MicrorocConfigDone = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic setup(input int s, input int e, input int st, input int mx,
                       input int wpp, input int tmo);
    StartDAC         = DAC_W'(s);
    EndDAC           = DAC_W'(e);
    DACStep          = DAC_W'(st);
    MaxPackageNumber = CNT_W'(mx);
    TimeoutCycles    = TIMEOUT_W'(tmo);
    words_pp         = wpp;
    act_q.delete();
    sent_q.delete();
    stored_cnt.delete();
    dac_seen.delete();
    done_cnt  = 0;
    acq_cyc   = 0;
    extra_acq = 0;
    sent_pt   = 0;
  endtask

  task automatic kick(input string name);
    int k = 0;
    @(negedge clk);
    SweepStart = 1'b1;
    while (!Busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({name, ":busy_rise"}, 32'(Busy), 32'd1);
    SweepStart = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (Busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check({name, ":busy_fall"}, 32'(Busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic verify(input string name, input int s, input int e, input int st,
                        input int mx, input int wpp, input bit exp_ovf,
                        input bit exp_tmo, input int exp_acq_cyc);
    int pts[$];
    logic [DATA_W-1:0] exp_q[$];
    int se, v, nv, n, per;
    bit up;
    se = (st == 0) ? 1 : st;
    up = (e >= s);
    v  = s;
    forever begin
      pts.push_back(v);
      nv = up ? v + se : v - se;
      if (up ? (nv > e) : (nv < e)) break;
      v = nv;
    end
    per = (mx < wpp) ? mx : wpp;
    if (per > FIFO_DEPTH) per = FIFO_DEPTH;
    for (int i = 0; i < pts.size(); i++) begin
      exp_q.push_back(DATA_W'(HDR_BASE | pts[i]));
      n = (i < stored_cnt.size()) ? stored_cnt[i] : 0;
      for (int j = 0; j < n && sent_q.size() > 0; j++) exp_q.push_back(sent_q.pop_front());
    end

    check({name, ":sc_loads"}, 32'(dac_seen.size()), 32'(pts.size()));
    for (int i = 0; i < pts.size() && i < dac_seen.size(); i++)
      check($sformatf("%s:dac%0d", name, i), 32'(dac_seen[i]), 32'(pts[i]));
    check({name, ":acq_points"}, 32'(stored_cnt.size()), (mx == 0) ? 32'd0 : 32'(pts.size()));
    for (int i = 0; i < stored_cnt.size(); i++)
      check($sformatf("%s:stored%0d", name, i), 32'(stored_cnt[i]), 32'(per));
    check({name, ":stream_len"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s:word%0d", name, i), 32'(act_q[i]), 32'(exp_q[i]));
    check({name, ":acq_done"}, 32'(done_cnt), 32'd1);
    check({name, ":overflow"}, 32'(Overflow), 32'(exp_ovf));
    check({name, ":timeout_flag"}, 32'(TimeoutFlag), 32'(exp_tmo));
    if (mx > 0 && mx == wpp) begin
      check({name, ":acq_after_last"}, 32'(extra_acq), 32'd0);
      check({name, ":strobes"}, 32'(sent_pt), 32'(wpp));
    end
    if (exp_acq_cyc >= 0) check({name, ":acq_cycles"}, 32'(acq_cyc), 32'(exp_acq_cyc));
  endtask

  task automatic run_sweep(input string name, input int s, input int e, input int st,
                           input int mx, input int wpp, input int tmo,
                           input bit exp_ovf, input bit exp_tmo, input int exp_acq_cyc);
    setup(s, e, st, mx, wpp, tmo);
    kick(name);
    wait_idle(name);
    verify(name, s, e, st, mx, wpp, exp_ovf, exp_tmo, exp_acq_cyc);
  endtask

  initial begin
    int s, e, st, mx, k;
    SweepStart = 1'b0;
    SweepAbort = 1'b0;
    cfg_delay  = 0;
    setup(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("reset:outdac", 32'(OutDAC), 32'd0);
    check("reset:outputs", 32'({LoadSCParameter, SingleACQStart, SweepACQData, SweepACQData_en,
                                ACQDone, Busy, Overflow, TimeoutFlag}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_sweep("up", 10, 14, 2, 3, 3, 0, 1'b0, 1'b0, -1);
    check("up:hdr0", 32'(act_q[0]), 32'h0000_FC0A);
    check("up:hdr1", 32'(act_q[4]), 32'h0000_FC0C);
    check("up:hdr2", 32'(act_q[8]), 32'h0000_FC0E);

    cfg_delay = 2;
    run_sweep("down", 5, 0, 3, 2, 2, 0, 1'b0, 1'b0, -1);
    run_sweep("step0_top", 1020, 1023, 0, 1, 1, 0, 1'b0, 1'b0, -1);
    cfg_delay = 1;
    run_sweep("overflow", 500, 500, 7, 200, 200, 0, 1'b1, 1'b0, -1);

`ifdef SWEEP_TIMEOUT_EN
    run_sweep("timeout", 100, 101, 1, 5, 0, 50, 1'b0, 1'b1, 100);
`endif

    // Abort during the first DRAIN cycle of the second point, then restart.
    setup(20, 40, 5, 4, 4, 0);
    kick("abort");
    k = 0;
    while (act_q.size() < 6 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort:reached_point2", 32'(act_q.size()), 32'd6);
    SweepAbort = 1'b1;
    @(negedge clk);
    SweepAbort = 1'b0;
    check("abort:busy", 32'(Busy), 32'd0);
    check("abort:acq_start", 32'(SingleACQStart), 32'd0);
    repeat (4) @(negedge clk);
    check("abort:no_done", 32'(done_cnt), 32'd0);
    check("abort:no_more_words", 32'(act_q.size()), 32'd6);
    run_sweep("restart", 20, 40, 5, 4, 4, 0, 1'b0, 1'b0, -1);

    for (int r = 0; r < 2; r++) begin
      s  = int'($urandom_range(0, 1023));
      k  = int'($urandom_range(0, 40));
      e  = ($urandom_range(0, 1) == 1) ? ((s + k > 1023) ? 1023 : s + k)
                                       : ((s - k < 0) ? 0 : s - k);
      st = int'($urandom_range(0, 15));
      mx = int'($urandom_range(1, 6));
      cfg_delay = int'($urandom_range(1, 3));
      run_sweep($sformatf("rand%0d", r), s, e, st, mx, mx, 0, 1'b0, 1'b0, -1);
    end

    // Asynchronous reset while acquiring, then a headers-only sweep.
    setup(3, 9, 3, 50, 50, 0);
    kick("rst_acq");
    k = 0;
    while (!SingleACQStart && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_acq:in_acq", 32'(SingleACQStart), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_acq:outdac", 32'(OutDAC), 32'd0);
    check("rst_acq:outputs", 32'({LoadSCParameter, SingleACQStart, SweepACQData, SweepACQData_en,
                                  ACQDone, Busy, Overflow, TimeoutFlag}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sweep("max0", 3, 9, 3, 0, 0, 0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
